// File: rtl/deck_pkg.sv
// ---------------------------------------------------------------------------
// deck_pkg
// Shared constants and types for the card-deck shuffler.
//   CARD_COUNT / RANKS / SUITS : deck geometry (52 = 13 ranks x 4 suits)
//   card_t                     : 6-bit card code, suit*13 + rank
//   SUIT_* / RANK_*            : named suit and rank values
//   state_t                    : controller state encoding
// Compile-time option: DECK_SHUFFLER_ORDERED_EN (see deck_shuffler.sv).
// ---------------------------------------------------------------------------
package deck_pkg;

  localparam int RANKS      = 13;
  localparam int SUITS      = 4;
  localparam int CARD_COUNT = RANKS * SUITS;

  typedef logic [5:0] card_t;

  localparam logic [1:0] SUIT_CLUBS    = 2'd0;
  localparam logic [1:0] SUIT_DIAMONDS = 2'd1;
  localparam logic [1:0] SUIT_HEARTS   = 2'd2;
  localparam logic [1:0] SUIT_SPADES   = 2'd3;

  localparam logic [3:0] RANK_ACE   = 4'd0;
  localparam logic [3:0] RANK_JACK  = 4'd10;
  localparam logic [3:0] RANK_QUEEN = 4'd11;
  localparam logic [3:0] RANK_KING  = 4'd12;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    INIT    = 3'd1,
    PICK    = 3'd2,
    SWAP_RD = 3'd3,
    SWAP_WR = 3'd4,
    STREAM  = 3'd5,
    DONE    = 3'd6
  } state_t;

  // Builds a card code from a suit and a rank.
  function automatic card_t make_card(input logic [1:0] suit, input logic [3:0] rank);
    return card_t'({4'd0, suit}) * card_t'(RANKS) + card_t'({2'd0, rank});
  endfunction

endpackage

// File: rtl/deck_lfsr.sv
// ---------------------------------------------------------------------------
// deck_lfsr
// 6-bit maximal-length Fibonacci LFSR, polynomial x^6 + x^5 + 1 (period 63).
// Steps on every rising clock edge once reset is released.
//   clk  : clock
//   rst  : asynchronous active-low reset, loads SEED (0 is mapped to 1)
//   q    : current LFSR state, never zero
// ---------------------------------------------------------------------------
module deck_lfsr #(
  parameter logic [5:0] SEED = 6'h2D
) (
  input  logic       clk,
  input  logic       rst,
  output logic [5:0] q
);

  // An all-zero state would lock the register forever.
  localparam logic [5:0] START = (SEED == 6'h00) ? 6'h01 : SEED;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= START;
    end else begin
      q <= {q[4:0], q[5] ^ q[4]};
    end
  end

endmodule

// File: rtl/deck_shuffler.sv
// ---------------------------------------------------------------------------
// deck_shuffler
// Builds a 52-card deck, shuffles it in place with a Fisher-Yates pass driven
// by a 6-bit LFSR (rejection sampling), then streams the cards out with a
// valid/ready handshake, one card per cycle when the consumer keeps up.
//   clk        : clock, rising edge
//   rst        : asynchronous active-low reset
//   start      : request a new shuffle (honoured only in IDLE or DONE)
//   card_ready : consumer accepts the presented card
//   busy       : shuffle/stream in progress
//   card_valid : card holds a dealt card
//   card       : card code, suit*13 + rank
//   cards_left : cards not yet accepted
//   done       : whole deck delivered, held until the next start
// Compile-time option: define DECK_SHUFFLER_ORDERED_EN to skip the shuffle
// and deal the deck in order 0..51.
// ---------------------------------------------------------------------------
module deck_shuffler #(
  parameter logic [5:0] SEED       = 6'h2D,
  parameter int         CARD_COUNT = 52
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       card_ready,
  output logic       busy,
  output logic       card_valid,
  output logic [5:0] card,
  output logic [5:0] cards_left,
  output logic       done
);

  import deck_pkg::*;

  localparam logic [5:0] LAST_IDX = 6'(CARD_COUNT - 1);
  localparam logic [5:0] FULL_CNT = 6'(CARD_COUNT);

  state_t state, state_next;

  card_t       deck [CARD_COUNT];
  logic [5:0]  i;
  logic [5:0]  i_inc;
  logic [5:0]  lfsr_q;

  logic start_ok;
  logic init_we;
  logic init_last;
  logic load_first;
  logic xfer;
  logic last_card;

`ifndef DECK_SHUFFLER_ORDERED_EN
  logic [5:0] j;
  logic [5:0] r;
  card_t      a_val;
  card_t      b_val;
  logic       pick_hit;
  logic       swap_rd;
  logic       swap_we;
  logic       swap_last;
`endif

  deck_lfsr #(
    .SEED (SEED)
  ) u_lfsr (
    .clk (clk),
    .rst (rst),
    .q   (lfsr_q)
  );

  assign i_inc     = i + 6'd1;
  assign last_card = (cards_left == 6'd1);

`ifndef DECK_SHUFFLER_ORDERED_EN
  // LFSR never reads zero, so r spans 0..62.
  assign r         = lfsr_q - 6'd1;
  assign swap_last = (i == 6'd1);
`endif

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: begin
        if (start) state_next = INIT;
      end
      INIT: begin
`ifdef DECK_SHUFFLER_ORDERED_EN
        if (init_last) state_next = STREAM;
`else
        if (init_last) state_next = PICK;
`endif
      end
`ifndef DECK_SHUFFLER_ORDERED_EN
      PICK: begin
        if (pick_hit) state_next = SWAP_RD;
      end
      SWAP_RD: begin
        state_next = SWAP_WR;
      end
      SWAP_WR: begin
        state_next = swap_last ? STREAM : PICK;
      end
`endif
      STREAM: begin
        if (xfer && last_card) state_next = DONE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Per-state control strobes for the datapath and deck storage.
  always_comb begin
    start_ok   = 1'b0;
    init_we    = 1'b0;
    init_last  = 1'b0;
    load_first = 1'b0;
    xfer       = 1'b0;
`ifndef DECK_SHUFFLER_ORDERED_EN
    pick_hit   = 1'b0;
    swap_rd    = 1'b0;
    swap_we    = 1'b0;
`endif
    case (state)
      IDLE, DONE: begin
        start_ok = start;
      end
      INIT: begin
        init_we   = 1'b1;
        init_last = (i == LAST_IDX);
      end
`ifndef DECK_SHUFFLER_ORDERED_EN
      PICK: begin
        pick_hit = (r <= i);
      end
      SWAP_RD: begin
        swap_rd = 1'b1;
      end
      SWAP_WR: begin
        swap_we = 1'b1;
      end
`endif
      STREAM: begin
        // card_valid is low in STREAM only on the entry cycle.
        load_first = !card_valid;
        xfer       = card_valid && card_ready;
      end
      default: begin
      end
    endcase
  end

  // Index, swap latches and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      i          <= 6'd0;
      busy       <= 1'b0;
      card_valid <= 1'b0;
      card       <= 6'd0;
      cards_left <= 6'd0;
      done       <= 1'b0;
`ifndef DECK_SHUFFLER_ORDERED_EN
      j          <= 6'd0;
      a_val      <= 6'd0;
      b_val      <= 6'd0;
`endif
    end else begin
      if (start_ok) begin
        busy       <= 1'b1;
        done       <= 1'b0;
        card_valid <= 1'b0;
        i          <= 6'd0;
      end

      if (init_we) begin
        if (init_last) begin
`ifdef DECK_SHUFFLER_ORDERED_EN
          i          <= 6'd0;
          cards_left <= FULL_CNT;
`else
          i          <= LAST_IDX;
`endif
        end else begin
          i <= i_inc;
        end
      end

`ifndef DECK_SHUFFLER_ORDERED_EN
      if (pick_hit) begin
        j <= r;
      end

      if (swap_rd) begin
        a_val <= deck[i];
        b_val <= deck[j];
      end

      if (swap_we) begin
        if (swap_last) begin
          i          <= 6'd0;
          cards_left <= FULL_CNT;
        end else begin
          i <= i - 6'd1;
        end
      end
`endif

      if (load_first) begin
        card       <= deck[i];
        card_valid <= 1'b1;
      end

      // The next card is fetched on the same edge as the transfer so the
      // stream sustains one card per cycle.
      if (xfer) begin
        if (last_card) begin
          card_valid <= 1'b0;
          cards_left <= 6'd0;
          busy       <= 1'b0;
          done       <= 1'b1;
        end else begin
          i          <= i_inc;
          cards_left <= cards_left - 6'd1;
          card       <= deck[i_inc];
        end
      end
    end
  end

  // Deck storage; contents are meaningless until INIT has filled it.
  always_ff @(posedge clk) begin
    if (init_we) begin
      deck[i] <= i;
    end
`ifndef DECK_SHUFFLER_ORDERED_EN
    // When j == i both writes target one entry with identical data.
    if (swap_we) begin
      deck[i] <= b_val;
      deck[j] <= a_val;
    end
`endif
  end

endmodule

// File: tb/tb_deck_shuffler.sv
// ---------------------------------------------------------------------------
// tb_deck_shuffler
// Self-checking bench for deck_shuffler: a table of dealing profiles (consumer
// ready rate, stall position/length, start pokes) plus hand-written reset and
// seed sequences. The reference model is a scoreboard of cards seen, the
// expected cards-remaining count and the handshake hold rule.
// ---------------------------------------------------------------------------
module tb_deck_shuffler;

  import deck_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       card_ready;
  logic       sel;

  logic       busy0, card_valid0, done0;
  logic [5:0] card0, cards_left0;
  logic       busy1, card_valid1, done1;
  logic [5:0] card1, cards_left1;

  logic       m_busy, m_card_valid, m_done;
  logic [5:0] m_card, m_cards_left;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int ready_pct;
    int stall_at;
    int stall_len;
    bit poke;
  } vec_t;

  always #5 clk = ~clk;

  deck_shuffler #(
    .SEED       (6'h2D),
    .CARD_COUNT (52)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .card_ready (card_ready),
    .busy       (busy0),
    .card_valid (card_valid0),
    .card       (card0),
    .cards_left (cards_left0),
    .done       (done0)
  );

  deck_shuffler #(
    .SEED       (6'h00),
    .CARD_COUNT (52)
  ) u_dut_zero (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .card_ready (card_ready),
    .busy       (busy1),
    .card_valid (card_valid1),
    .card       (card1),
    .cards_left (cards_left1),
    .done       (done1)
  );

  assign m_busy       = sel ? busy1       : busy0;
  assign m_card_valid = sel ? card_valid1 : card_valid0;
  assign m_done       = sel ? done1       : done0;
  assign m_card       = sel ? card1       : card0;
  assign m_cards_left = sel ? cards_left1 : cards_left0;

  task automatic check_output(input string name, input int actual, input int expected);
    tests++;
    if (actual != expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input logic s, input logic r);
    start      = s;
    card_ready = r;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, " busy"},       int'(m_busy),       0);
    check_output({tag, " card_valid"}, int'(m_card_valid), 0);
    check_output({tag, " card"},       int'(m_card),       0);
    check_output({tag, " cards_left"}, int'(m_cards_left), 0);
    check_output({tag, " done"},       int'(m_done),       0);
  endtask

  // Starts a shuffle and consumes cards until done. abort_left >= 0 stops
  // the deal as soon as that many cards remain (status 2).
  // status: 0 timeout, 1 done, 2 aborted.
  task automatic deal(input int ready_pct, input int stall_at, input int stall_len,
                      input bit poke, input int abort_left, output int status);
    int         seen [52];
    int         ncards;
    int         stall_cnt;
    int         distinct;
    bit         pv, pr, rdy;
    logic [5:0] pc, pl;
    logic       s;

    foreach (seen[k]) seen[k] = 0;
    ncards    = 0;
    stall_cnt = 0;
    status    = 0;
    pv        = 1'b0;
    pr        = 1'b0;
    pc        = 6'd0;
    pl        = 6'd0;

    apply_stimulus(1'b1, 1'b0);
    step();
    apply_stimulus(1'b0, 1'b0);
    check_output("busy after start", int'(m_busy), 1);
    check_output("done cleared after start", int'(m_done), 0);

    for (int cyc = 0; cyc < 6000; cyc++) begin
      if (m_done) begin
        status = 1;
        break;
      end
      if (abort_left >= 0 && m_card_valid && int'(m_cards_left) == abort_left) begin
        status = 2;
        break;
      end
      if (pv && !pr) begin
        check_output("hold card_valid", int'(m_card_valid), 1);
        check_output("hold card", int'(m_card), int'(pc));
        check_output("hold cards_left", int'(m_cards_left), int'(pl));
      end
      if (m_card_valid) begin
        check_output("cards_left", int'(m_cards_left), 52 - ncards);
      end
      if (stall_at >= 0 && m_card_valid && ncards == stall_at && stall_cnt < stall_len) begin
        rdy = 1'b0;
        stall_cnt++;
      end else begin
        rdy = ($urandom_range(99) < 32'(ready_pct));
      end
      s = (poke && m_busy) ? 1'($urandom_range(1)) : 1'b0;
      apply_stimulus(s, rdy);
      if (m_card_valid && rdy) begin
        if (m_card < 6'd52) begin
          seen[m_card]++;
        end else begin
          check_output("card range", int'(m_card), 51);
        end
`ifdef DECK_SHUFFLER_ORDERED_EN
        check_output("ordered card", int'(m_card), ncards);
`endif
        ncards++;
      end
      pv = m_card_valid;
      pr = rdy;
      pc = m_card;
      pl = m_cards_left;
      step();
    end
    apply_stimulus(1'b0, 1'b0);

    if (status == 0) begin
      tests++;
      fails++;
      $display("[TB] FAIL deal timeout: got %0d cards, expected 52 and done", ncards);
    end else if (status == 1) begin
      distinct = 0;
      foreach (seen[k]) if (seen[k] == 1) distinct++;
      check_output("cards dealt", ncards, 52);
      check_output("permutation distinct", distinct, 52);
      check_output("end busy", int'(m_busy), 0);
      check_output("end card_valid", int'(m_card_valid), 0);
      check_output("end cards_left", int'(m_cards_left), 0);
      repeat (3) step();
      check_output("done held", int'(m_done), 1);
      check_output("idle busy after done", int'(m_busy), 0);
    end
  endtask

  task automatic reset_pulse(input string tag);
    rst = 1'b0;
    #1;
    check_all_zero(tag);
    step();
    step();
    rst = 1'b1;
    repeat (5) step();
    check_output({tag, " released busy"},  int'(m_busy),       0);
    check_output({tag, " released valid"}, int'(m_card_valid), 0);
    check_output({tag, " released done"},  int'(m_done),       0);
  endtask

  initial begin
    vec_t vecs [6];
    int   st;
    int   cnt;

    vecs[0] = '{ready_pct: 100, stall_at: -1, stall_len: 0,  poke: 1'b0};
    vecs[1] = '{ready_pct: 100, stall_at: -1, stall_len: 0,  poke: 1'b0};
    vecs[2] = '{ready_pct: 100, stall_at: -1, stall_len: 0,  poke: 1'b0};
    vecs[3] = '{ready_pct: 100, stall_at: 5,  stall_len: 10, poke: 1'b0};
    vecs[4] = '{ready_pct: 60,  stall_at: -1, stall_len: 0,  poke: 1'b1};
    vecs[5] = '{ready_pct: 25,  stall_at: 30, stall_len: 4,  poke: 1'b1};

    sel = 1'b0;
    apply_stimulus(1'b0, 1'b0);
    rst = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    check_all_zero("reset");
    check_output("lfsr seed", int'(u_dut.u_lfsr.q), 'h2D);
    check_output("lfsr zero seed", int'(u_dut_zero.u_lfsr.q), 1);
    step();
    rst = 1'b1;
    repeat (4) step();
    check_all_zero("post reset idle");

    for (int v = 0; v < 6; v++) begin
      deal(vecs[v].ready_pct, vecs[v].stall_at, vecs[v].stall_len, vecs[v].poke, -1, st);
      check_output($sformatf("vector %0d completed", v), st, 1);
    end

    // Reset in the middle of the swap phase (or INIT when no shuffle exists).
    apply_stimulus(1'b1, 1'b0);
    step();
    apply_stimulus(1'b0, 1'b0);
    cnt = 0;
`ifdef DECK_SHUFFLER_ORDERED_EN
    while (u_dut.state != INIT && cnt < 2000) begin
`else
    while (u_dut.state != SWAP_WR && cnt < 2000) begin
`endif
      step();
      cnt++;
    end
    check_output("reached swap phase", int'(cnt < 2000), 1);
    reset_pulse("reset mid swap");
    deal(100, -1, 0, 1'b0, -1, st);
    check_output("deal after swap reset", st, 1);

    // Reset mid-stream with 20 cards remaining.
    deal(100, -1, 0, 1'b0, 20, st);
    check_output("reached cards_left 20", st, 2);
    reset_pulse("reset mid stream");
    deal(70, -1, 0, 1'b0, -1, st);
    check_output("deal after stream reset", st, 1);

    // Zero seed instance.
    sel = 1'b1;
    rst = 1'b0;
    #1;
    check_output("zero seed lfsr reset", int'(u_dut_zero.u_lfsr.q), 1);
    step();
    rst = 1'b1;
    for (int k = 0; k < 70; k++) begin
      step();
      check_output("zero seed lfsr nonzero", int'(u_dut_zero.u_lfsr.q != 6'd0), 1);
    end
    deal(100, -1, 0, 1'b0, -1, st);
    check_output("zero seed deal", st, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/deck_shuffler.md
DECK_SHUFFLER -- requirements
Module: deck_shuffler

Interface
REQ-001 Parameter SEED, default 6'h2D, initial LFSR state; a value of 0 SHALL be replaced by 6'h01.
REQ-002 Parameter CARD_COUNT, default 52, deck size; SHALL be fixed at 52.
REQ-003 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request a new shuffle; sampled only in IDLE or DONE.
REQ-006 card_ready  input  1  consumer accepts the presented card.
REQ-007 busy  output  1  high from the cycle after an accepted start until the last card is accepted.
REQ-008 card_valid  output  1  card holds a valid dealt card.
REQ-009 card  output  6  card code 0..51, encoded as suit*13+rank; suits clubs, diamonds, hearts, spades; rank 0=Ace .. 12=King.
REQ-010 cards_left  output  6  cards not yet accepted, 52..0.
REQ-011 done  output  1  whole deck delivered; held until the next accepted start.

Function
REQ-012 The FSM SHALL have exactly these states: IDLE, INIT, PICK, SWAP_RD, SWAP_WR, STREAM, DONE.
REQ-013 IDLE or DONE with start=1: the FSM SHALL go to INIT, set busy=1, clear done, set index i=0.
REQ-014 start SHALL be ignored in every other state.
REQ-015 INIT SHALL write deck[i]=i for i=0..51, one entry per cycle (52 cycles), then go to PICK with i=51.
REQ-016 A 6-bit maximal-length LFSR (x^6+x^5+1) SHALL step every cycle after reset, in every state.
REQ-017 PICK SHALL draw r = lfsr-1 (range 0..62).
REQ-018 In PICK, r>i SHALL be rejected and redrawn next cycle; otherwise j=r and the FSM goes to SWAP_RD.
REQ-019 SWAP_RD SHALL latch deck[i] and deck[j]; SWAP_WR SHALL write the swapped values (a no-op when j==i).
REQ-020 After SWAP_WR: if i==1, the FSM SHALL go to STREAM with i=0 and cards_left=52; otherwise it SHALL decrement i and return to PICK.
REQ-021 STREAM SHALL present card=deck[i] with card_valid=1 no later than 2 cycles after entry.
REQ-022 A transfer SHALL occur only on a cycle with card_valid && card_ready.
REQ-023 On each transfer, i SHALL increment, cards_left SHALL decrement, and the next card SHALL be presented the following cycle (one card per cycle sustained).
REQ-024 While card_valid && !card_ready, card SHALL be held stable and card_valid SHALL stay high.
REQ-025 card_ready while card_valid=0 SHALL have no effect.
REQ-026 When the transfer with cards_left==1 occurs: card_valid=0, cards_left=0, busy=0, done=1, and the FSM goes to DONE on the same edge.
REQ-027 The emitted 52 cards SHALL be a permutation of 0..51.

Reset
REQ-028 rst low SHALL immediately force: FSM=IDLE, busy=0, card_valid=0, card=0, cards_left=0, done=0, LFSR=SEED, i=0, j=0; deck contents are don't-care.
REQ-029 Reset asserted in any state (including mid-INIT, mid-swap or mid-stream) SHALL abandon the operation; after release, only a new start SHALL resume activity.

Configuration
REQ-030 Macro DECK_SHUFFLER_ORDERED_EN SHALL control ordered mode.
REQ-031 With DECK_SHUFFLER_ORDERED_EN defined, PICK/SWAP_RD/SWAP_WR SHALL be compiled out: INIT goes directly to STREAM and cards emit in order 0,1,..,51.
REQ-032 With DECK_SHUFFLER_ORDERED_EN undefined, shuffled behaviour per REQ-016..020 applies.

Structure
REQ-033 Package deck_pkg SHALL hold: CARD_COUNT=52, RANKS=13, SUITS=4, card_t (6-bit), suit/rank constants, and the FSM state enum; the deck_shuffler and the controller SHALL both import it.
REQ-034 The LFSR SHALL be one sub-module, deck_lfsr (ports clk, rst, q[5:0], parameter SEED).
REQ-035 Deck storage SHALL be a 52x6 register array inside deck_shuffler.

Verification
REQ-036 ORDERED_EN build, start pulse, card_ready=1 -> busy next cycle, cards 0..51 in order, done=1 after the 52nd transfer, cards_left 52..0.
REQ-037 Shuffled build, start, card_ready=1 -> 52 cards, each of 0..51 exactly once; three back-to-back shuffles, each one a permutation.
REQ-038 card_ready=0 for 10 cycles while card 5 is presented -> card and card_valid stable for all 10 cycles, cards_left=47 throughout, no card lost or duplicated.
REQ-039 start pulsed repeatedly during INIT and STREAM -> ignored, sequence unaffected, single done.
REQ-040 rst low mid-SWAP, then mid-STREAM (cards_left=20) -> all outputs 0 during reset, IDLE after release, next start yields a full valid permutation.
REQ-041 SEED=0 -> LFSR runs from 6'h01, never locks at zero, shuffle completes.
